// File: rtl/dbus_responder.sv
// Data-bus responder for the single-cycle core: word RAM in the low half of the address map,
// MMIO in the high half. Defining DBUS_TIMER_EN builds the compare timer, its flag and timer_irq.
module dbus_responder #(
    parameter int RAM_WORDS  = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        timer_irq
);
    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [5:0] {
        REG_COUNT     = 6'd0,
        REG_TXDATA    = 6'd1,
        REG_STATUS    = 6'd2,
        REG_TIMER_CMP = 6'd3
    } mmio_reg_e;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [AW-1:0] ram_idx;
    logic [5:0]    mmio_word;
    logic          sel_mmio;
    logic          ram_we;
    logic          mmio_we;
    logic          push;
    logic          status_we;
    logic          unused_adr;

    assign sel_mmio   = DataAdr[31];
    assign ram_idx    = DataAdr[AW+1:2];
    assign mmio_word  = DataAdr[7:2];
    assign ram_we     = MemWrite && !sel_mmio;
    assign mmio_we    = MemWrite && sel_mmio;
    assign push       = mmio_we && (mmio_word == REG_TXDATA);
    assign status_we  = mmio_we && (mmio_word == REG_STATUS);
    // Byte-offset and high MMIO bits play no part in decode; RAM and MMIO both alias.
    assign unused_adr = ^{DataAdr[30:8], DataAdr[1:0]};

    // ------------------------------------------------------------------
    // Word RAM
    // ------------------------------------------------------------------
    logic [31:0] ram_q [RAM_WORDS];

    // NOTE: storage arrays take no reset branch; only control state is reset, which keeps
    // the array mappable onto plain RAM cells.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_q[ram_idx] <= WriteData;
        end
    end

    // ------------------------------------------------------------------
    // Free-running cycle counter
    // ------------------------------------------------------------------
    logic [31:0] count_q;
    logic [31:0] count_d;

    assign count_d = count_q + 32'd1;

    // NOTE: sequential state is updated with <= only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // ------------------------------------------------------------------
    // Transmit FIFO
    // ------------------------------------------------------------------
    logic [31:0]   fifo_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          fifo_empty;
    logic          fifo_full;
    logic          pop;
    logic          push_ok;

    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == CW'(FIFO_DEPTH));
    assign pop        = !fifo_empty && tx_ready;
    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign push_ok    = push && (!fifo_full || pop);

    always_comb begin
        // NOTE: every next-state signal gets a default first, so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push_ok, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        if (status_we && WriteData[2]) begin
            ovf_d = 1'b0;
        end
        if (push && !push_ok) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_q[wr_ptr_q] <= WriteData;
        end
    end

    assign tx_valid = !fifo_empty;
    // Stale entries stay in the array after reset; gating keeps tx_data at 0 while empty.
    assign tx_data  = fifo_empty ? '0 : fifo_q[rd_ptr_q];

    // ------------------------------------------------------------------
    // Compare timer
    // ------------------------------------------------------------------
    logic [31:0] cmp_rd;
    logic        tmr_flag;

`ifdef DBUS_TIMER_EN
    logic [31:0] cmp_q, cmp_d;
    logic        tmr_q, tmr_d;
    logic        cmp_we;

    assign cmp_we = mmio_we && (mmio_word == REG_TIMER_CMP);

    always_comb begin
        cmp_d = cmp_we ? WriteData : cmp_q;
        tmr_d = tmr_q;
        if (status_we && WriteData[3]) begin
            tmr_d = 1'b0;
        end
        // A match on the same edge as a W1C clear leaves the flag set.
        if (count_q == cmp_q) begin
            tmr_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cmp_q <= '1;
            tmr_q <= 1'b0;
        end else begin
            cmp_q <= cmp_d;
            tmr_q <= tmr_d;
        end
    end

    assign cmp_rd   = cmp_q;
    assign tmr_flag = tmr_q;
`else
    assign cmp_rd   = '0;
    assign tmr_flag = 1'b0;
`endif

    assign timer_irq = tmr_flag;

    // ------------------------------------------------------------------
    // Read mux (combinational, side-effect free)
    // ------------------------------------------------------------------
    logic [3:0] occ;

    assign occ = 4'(cnt_q);

    always_comb begin
        ReadData = '0;
        if (!sel_mmio) begin
            ReadData = ram_q[ram_idx];
        end else begin
            case (mmio_word)
                REG_COUNT:     ReadData = count_q;
                REG_STATUS:    ReadData = {24'd0, occ, tmr_flag, ovf_q, fifo_full, fifo_empty};
                REG_TIMER_CMP: ReadData = cmp_rd;
                default:       ReadData = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_dbus_responder.sv
// Self-checking bench for dbus_responder: directed steps plus a randomized phase, all compared
// against a queue/array reference model. Honours DBUS_TIMER_EN the same way the design does.
module tb_dbus_responder;
    localparam int RAM_WORDS  = 64;
    localparam int FIFO_DEPTH = 4;
`ifdef DBUS_TIMER_EN
    localparam bit TIMER_EN = 1'b1;
`else
    localparam bit TIMER_EN = 1'b0;
`endif

    localparam logic [31:0] A_COUNT  = 32'h8000_0000;
    localparam logic [31:0] A_TX     = 32'h8000_0004;
    localparam logic [31:0] A_STATUS = 32'h8000_0008;
    localparam logic [31:0] A_CMP    = 32'h8000_000C;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemWrite = 1'b0;
    logic [31:0] DataAdr = '0;
    logic [31:0] WriteData = '0;
    logic [31:0] ReadData;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        timer_irq;

    dbus_responder #(
        .RAM_WORDS (RAM_WORDS),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .MemWrite (MemWrite),
        .DataAdr  (DataAdr),
        .WriteData(WriteData),
        .ReadData (ReadData),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .timer_irq(timer_irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_ram [RAM_WORDS];
    logic [31:0] m_fifo [$];
    logic [31:0] m_count;
    logic [31:0] m_cmp;
    logic        m_ovf;
    logic        m_tmr;

    // Values observed in the most recent step
    logic [31:0] rd_obs;
    logic [31:0] tx_obs;
    logic        valid_obs;
    logic        irq_obs;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_status();
        int n;
        n = m_fifo.size();
        return {24'd0, 4'(n), TIMER_EN & m_tmr, m_ovf, n == FIFO_DEPTH, n == 0};
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] adr);
        int idx;
        int word;
        idx  = int'((adr >> 2) % 32'(RAM_WORDS));
        word = int'((adr >> 2) & 32'h3F);
        if (!adr[31]) return m_ram[idx];
        case (word)
            0:       return m_count;
            2:       return m_status();
            3:       return TIMER_EN ? m_cmp : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] m_head();
        return (m_fifo.size() != 0) ? m_fifo[0] : 32'd0;
    endfunction

    task automatic model_reset();
        m_fifo.delete();
        m_count = '0;
        m_cmp   = 32'hFFFF_FFFF;
        m_ovf   = 1'b0;
        m_tmr   = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        reset    = 1'b1;
        MemWrite = 1'b0;
        tx_ready = 1'b0;
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // One bus cycle: drive at the falling edge, compare all outputs, then apply the
    // cycle's effect to the model on the rising edge.
    task automatic step(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                        input logic rdy);
        int  word;
        bit  tmr_hit;
        MemWrite  = we;
        DataAdr   = adr;
        WriteData = wd;
        tx_ready  = rdy;
        #1;
        rd_obs    = ReadData;
        tx_obs    = tx_data;
        valid_obs = tx_valid;
        irq_obs   = timer_irq;
        check("ReadData", rd_obs, m_read(adr));
        check("tx_valid", {31'd0, valid_obs}, {31'd0, m_fifo.size() != 0});
        check("tx_data", tx_obs, m_head());
        check("timer_irq", {31'd0, irq_obs}, {31'd0, TIMER_EN & m_tmr});
        @(posedge clk);
        word    = int'((adr >> 2) & 32'h3F);
        tmr_hit = (m_count == m_cmp);
        if (m_fifo.size() != 0 && rdy) void'(m_fifo.pop_front());
        if (we) begin
            if (!adr[31]) begin
                m_ram[int'((adr >> 2) % 32'(RAM_WORDS))] = wd;
            end else begin
                case (word)
                    1: begin
                        if (m_fifo.size() < FIFO_DEPTH) m_fifo.push_back(wd);
                        else m_ovf = 1'b1;
                    end
                    2: begin
                        if (wd[2]) m_ovf = 1'b0;
                        if (wd[3]) m_tmr = 1'b0;
                    end
                    3: m_cmp = wd;
                    default: ;
                endcase
            end
        end
        if (TIMER_EN && tmr_hit) m_tmr = 1'b1;
        m_count = m_count + 32'd1;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation timed out");
    end

    initial begin
        bit          hit;
        logic [31:0] c;
        logic [31:0] exp_seq [4];
        int          op;
        logic [31:0] a;
        logic [31:0] d;
        logic        r;

        model_reset();
        do_reset(2);

        // Reset state and counter start
        step(0, A_COUNT, 0, 0);
        check("count_first_cycle", rd_obs, 32'd0);
        check("reset_tx_valid", {31'd0, valid_obs}, 32'd0);
        check("reset_tx_data", tx_obs, 32'd0);
        check("reset_irq", {31'd0, irq_obs}, 32'd0);
        repeat (3) step(0, A_COUNT, 0, 0);
        step(0, A_COUNT, 0, 0);
        check("count_5th_cycle", rd_obs, 32'd4);
        step(0, A_STATUS, 0, 0);
        check("reset_status", rd_obs, 32'h1);
        step(0, A_CMP, 0, 0);
        check("reset_timer_cmp", rd_obs, TIMER_EN ? 32'hFFFF_FFFF : 32'd0);

        // Timer match at COUNT == 20
        step(1, A_CMP, 32'd20, 0);
        hit = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (!hit) begin
                step(0, A_COUNT, 0, 0);
                if (rd_obs == 32'd20) hit = 1'b1;
            end
        end
        check("count_reached_20", {31'd0, hit}, 32'd1);
        check("irq_during_match", {31'd0, irq_obs}, 32'd0);
        step(0, A_STATUS, 0, 0);
        check("irq_after_match", {31'd0, irq_obs}, 32'(TIMER_EN));

        // W1C of tmr in the same cycle as a match: set wins
        c = m_count;
        step(1, A_CMP, c + 32'd4, 0);
        step(1, A_STATUS, 32'h8, 0);
        step(0, A_STATUS, 0, 0);
        check("irq_cleared", {31'd0, irq_obs}, 32'd0);
        step(0, A_COUNT, 0, 0);
        step(1, A_STATUS, 32'h8, 0);
        step(0, A_STATUS, 0, 0);
        check("irq_set_beats_clear", {31'd0, irq_obs}, 32'(TIMER_EN));
        step(1, A_STATUS, 32'hC, 0);

        // RAM: fill every word, then store/load with alias
        for (int i = 0; i < RAM_WORDS; i++) step(1, 32'(i * 4), $urandom, 0);
        step(1, 32'h0000_0010, 32'hDEAD_BEEF, 0);
        step(0, 32'h0000_0010, 0, 0);
        check("ram_load", rd_obs, 32'hDEAD_BEEF);
        step(0, 32'h0000_0110, 0, 0);
        check("ram_alias", rd_obs, 32'hDEAD_BEEF);

        // FIFO fill, overflow, drain, W1C ovf
        for (int v = 1; v <= 4; v++) step(1, A_TX, 32'(v), 0);
        step(0, A_STATUS, 0, 0);
        check("status_full", rd_obs, 32'h42);
        step(1, A_TX, 32'd99, 0);
        step(0, A_STATUS, 0, 0);
        check("status_ovf", rd_obs, 32'h46);
        for (int k = 0; k < 4; k++) begin
            step(0, A_STATUS, 0, 1);
            check("drain_data", tx_obs, 32'(k + 1));
        end
        step(0, A_STATUS, 0, 0);
        check("drain_empty", {31'd0, valid_obs}, 32'd0);
        check("status_empty_ovf", rd_obs, 32'h5);
        step(1, A_STATUS, 32'h4, 0);
        step(0, A_STATUS, 0, 0);
        check("ovf_w1c", rd_obs, 32'h1);

        // Push and pop together on a full FIFO
        for (int v = 1; v <= 4; v++) step(1, A_TX, 32'(v), 0);
        step(1, A_TX, 32'd5, 1);
        step(0, A_STATUS, 0, 0);
        check("full_push_pop_status", rd_obs, 32'h42);
        exp_seq[0] = 32'd2;
        exp_seq[1] = 32'd3;
        exp_seq[2] = 32'd4;
        exp_seq[3] = 32'd5;
        for (int k = 0; k < 4; k++) begin
            step(0, A_STATUS, 0, 1);
            check("push_pop_order", tx_obs, exp_seq[k]);
        end
        step(0, A_STATUS, 0, 0);
        check("push_pop_empty", {31'd0, valid_obs}, 32'd0);

        // Push and pop together on an empty FIFO: push taken, no pop
        step(1, A_TX, 32'hA5A5_0001, 1);
        step(0, A_STATUS, 0, 0);
        check("empty_push_pop", tx_obs, 32'hA5A5_0001);
        step(0, A_STATUS, 0, 1);

        // Counter wrap
        force dut.count_q = 32'hFFFF_FFFF;
        #1;
        release dut.count_q;
        m_count = 32'hFFFF_FFFF;
        step(0, A_COUNT, 0, 0);
        check("count_max", rd_obs, 32'hFFFF_FFFF);
        step(0, A_COUNT, 0, 0);
        check("count_wrap", rd_obs, 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            op = int'($urandom_range(0, 7));
            a  = $urandom;
            d  = $urandom;
            r  = 1'($urandom_range(0, 1));
            case (op)
                0:    step(1, {1'b0, a[30:0]}, d, r);
                1:    step(0, {1'b0, a[30:0]}, d, r);
                2, 3: step(1, {1'b1, a[30:8], 6'd1, a[1:0]}, d, r);
                4:    step(1'($urandom_range(0, 1)), {1'b1, a[30:8], 6'd2, a[1:0]}, d, r);
                5:    step(0, {1'b1, a[30:8], 6'd0, a[1:0]}, d, r);
                6:    step(1, {1'b1, a[30:8], 6'd3, a[1:0]},
                           m_count + 32'($urandom_range(1, 6)), r);
                default: step(1'($urandom_range(0, 1)),
                              {1'b1, a[30:8], 6'($urandom_range(4, 63)), a[1:0]}, d, r);
            endcase
        end

        // Reset with entries queued
        for (int k = 0; k < 20; k++) begin
            if (m_fifo.size() != 0) step(0, A_STATUS, 0, 1);
        end
        for (int v = 0; v < 3; v++) step(1, A_TX, $urandom, 0);
        step(0, A_STATUS, 0, 0);
        check("queued_before_reset", {31'd0, valid_obs}, 32'd1);
        do_reset(1);
        step(0, A_STATUS, 0, 0);
        check("midreset_tx_valid", {31'd0, valid_obs}, 32'd0);
        check("midreset_status", rd_obs, 32'h1);
        check("midreset_irq", {31'd0, irq_obs}, 32'd0);
        step(0, A_CMP, 0, 0);
        check("midreset_timer_cmp", rd_obs, TIMER_EN ? 32'hFFFF_FFFF : 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dbus_responder.md
# dbus_responder

Data-bus responder for the single-cycle RISC-V core. It sits on the core's data port (MemWrite, DataAdr, WriteData, ReadData) and replaces the plain data memory. It serves a word RAM in the low half of the address space. In the high half it exposes memory-mapped I/O:
- a free-running cycle counter,
- a 4-entry transmit FIFO drained by an external consumer over a valid/ready handshake,
- a compare timer with an interrupt flag.

## Interface
Parameters:
- RAM_WORDS, 64: RAM depth in 32-bit words; power of 2.
- FIFO_DEPTH, 4: TX FIFO entries; power of 2, at least 2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- MemWrite  in  1  write strobe from the core.
- DataAdr  in  32  byte address from the core; bits [1:0] are ignored (word access only).
- WriteData  in  32  store data.
- ReadData  out  32  load data; combinational from DataAdr.
- tx_data  out  32  FIFO head word.
- tx_valid  out  1  FIFO non-empty.
- tx_ready  in  1  consumer accepts tx_data this cycle.
- timer_irq  out  1  timer expired flag.

## Operation
Address decode:
- DataAdr[31]=0 selects RAM.
  - Word index is DataAdr[log2(RAM_WORDS)+1:2]; upper bits are ignored, so RAM aliases.
  - Writes on the clock edge when MemWrite=1.
  - Reads are combinational.
- DataAdr[31]=1 selects MMIO, decoded on DataAdr[7:2]:
  - 0x8000_0000 COUNT, read-only. 32-bit cycle counter; increments every cycle and wraps 0xFFFF_FFFF→0.
  - 0x8000_0004 TXDATA, write-only; reads return 0. A write pushes WriteData into the FIFO.
  - 0x8000_0008 STATUS:
    - bit0 empty; bit1 full; bit2 ovf (sticky); bit3 tmr (sticky).
    - bits[7:4] occupancy count; all other bits 0.
    - Writing 1 to bit2 or bit3 clears that flag (W1C). Other bits ignore writes.
  - 0x8000_000C TIMER_CMP, read/write.
  - Any other MMIO word reads 0; writes to it are ignored.
- Reads never have side effects.

FIFO behaviour:
- A push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
- A push to a full FIFO with no simultaneous pop is dropped and sets ovf.
- A pop occurs on an edge where tx_valid and tx_ready are both 1.
- tx_data presents the head entry. It holds stable while tx_valid=1 and tx_ready=0.
- Pointers wrap modulo FIFO_DEPTH.
- Push and pop in the same cycle on an empty FIFO: there is no pop (tx_valid=0), and the push is accepted.

Timer behaviour:
- tmr is set on the edge where COUNT == TIMER_CMP.
- timer_irq equals tmr.
- If set and W1C clear happen in the same cycle, set wins.
- A COUNT match is checked every cycle, including after wrap.

## Timing
Reset values:
- COUNT=0; FIFO empty; ovf=0; tmr=0; TIMER_CMP=0xFFFF_FFFF.
- tx_valid=0; tx_data=0; timer_irq=0.
- RAM contents are not reset.

Reset mid-operation: all FIFO entries are discarded on that edge, and tx_valid drops to 0 the cycle after.

Latencies:
- ReadData: 0 cycles (combinational). A store at edge N is visible to loads in the cycle after N.
- COUNT reads 0 in the first cycle after reset deasserts, and reads k in the k-th cycle after that.
- TXDATA store at edge N on an empty FIFO gives tx_valid=1 in cycle N+1.
- Pop at edge N advances tx_data, or drops tx_valid, in cycle N+1.
- STATUS and timer_irq reflect state registered at the previous edge.

## Configuration
- DBUS_TIMER_EN defined: the TIMER_CMP register, the tmr flag and timer_irq are implemented as above.
- DBUS_TIMER_EN undefined:
  - TIMER_CMP reads 0 and ignores writes.
  - STATUS bit3 reads 0.
  - timer_irq is tied to 0.
  - COUNT, the FIFO and RAM are unchanged.

## Test plan
- RAM: store 0xDEAD_BEEF to 0x0000_0010, then load 0x0000_0010 → 0xDEAD_BEEF. Load 0x0000_0110 (alias with RAM_WORDS=64) → 0xDEAD_BEEF.
- Counter: release reset, load 0x8000_0000 in the 5th cycle after deassert → 4. Preload via force to 0xFFFF_FFFF → reads 0 the next cycle.
- FIFO fill/overflow, tx_ready=0:
  - Store 1,2,3,4 to TXDATA → STATUS=0x42 (full, count 4).
  - 5th store → STATUS=0x46 (ovf set).
  - Raise tx_ready → tx_data sequence 1,2,3,4, one per cycle, then tx_valid=0.
  - Write 0x4 to STATUS → ovf cleared.
- Simultaneous push/pop on a full FIFO with tx_ready=1: store 5 → accepted, count stays 4, 5 emerges after 2,3,4.
- Timer (DBUS_TIMER_EN): write TIMER_CMP=20 → timer_irq=1 the cycle after COUNT reads 20. W1C 0x8 in the same cycle as a match → tmr stays 1. Without the macro, timer_irq stays 0 throughout.
- Reset mid-stream: 3 entries queued, assert reset for 1 cycle → tx_valid=0, STATUS=0x1, TIMER_CMP=0xFFFF_FFFF.
